// File: rtl/frecmd_regbank.sv
// SPI command decoder and register bank: gate-time writes, channel/ID/status readback, error counter.
// Optional FRECMD_SNAPSHOT_EN: a channel-0 read snapshots every channel so later reads are coherent.
module frecmd_regbank #(
    parameter int                DATA_W       = 32,
    parameter int                NCH          = 4,
    parameter int                GATE_W       = 24,
    parameter logic [GATE_W-1:0] GATE_DEFAULT = 24'd1_000_000,
    parameter logic [15:0]       ID_WORD      = 16'h5AA5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NCH*DATA_W-1:0] ch_data,
    input  logic [DATA_W-1:0]     spi_rx_data,
    input  logic                  spi_rx_valid,
    output logic [DATA_W-1:0]     spi_tx_data,
    output logic [GATE_W-1:0]     gate_time,
    output logic                  gate_update,
    output logic                  cmd_done,
    output logic                  cmd_err
);

    typedef enum logic [1:0] {IDLE, DECODE, EXEC} state_t;

    state_t              state, state_nxt;
    logic                r1, r2, pos;
    logic                accept, drop, exec;
    logic [3:0]          op, sel;
    logic [GATE_W-1:0]   pay;
    logic [7:0]          err_cnt;
    logic                busy_seen;
    logic [DATA_W-1:0]   ch [NCH];
    logic [DATA_W-1:0]   chan_word, rd_word;
    logic                rd_ok, gate_ok, clr, rej, snap_load;

    always_comb begin
        for (int k = 0; k < NCH; k++) ch[k] = ch_data[k*DATA_W +: DATA_W];
    end

    assign pos    = r1 & ~r2;
    assign accept = pos & (state == IDLE);
    assign drop   = pos & (state != IDLE);
    assign exec   = (state == EXEC);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r1 <= 1'b0;
            r2 <= 1'b0;
        end else begin
            r1 <= spi_rx_valid;
            r2 <= r1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (pos) state_nxt = DECODE;
            DECODE:  state_nxt = EXEC;
            EXEC:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Fields are captured on the edge that enters DECODE, while the SPI word is still stable.
    always_ff @(posedge clk) begin
        if (accept) begin
            op  <= spi_rx_data[DATA_W-1 -: 4];
            sel <= spi_rx_data[DATA_W-5 -: 4];
            pay <= spi_rx_data[GATE_W-1:0];
        end
    end

`ifdef FRECMD_SNAPSHOT_EN
    logic [DATA_W-1:0] shadow [NCH];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < NCH; k++) shadow[k] <= '0;
        end else if (snap_load) begin
            for (int k = 0; k < NCH; k++) shadow[k] <= ch[k];
        end
    end

    always_comb begin
        chan_word = ch[0];
        for (int k = 1; k < NCH; k++)
            if (int'(sel) == k) chan_word = shadow[k];
    end
`else
    always_comb begin
        chan_word = ch[0];
        for (int k = 1; k < NCH; k++)
            if (int'(sel) == k) chan_word = ch[k];
    end
`endif

    always_comb begin
        rd_ok     = 1'b0;
        rd_word   = spi_tx_data;
        gate_ok   = 1'b0;
        clr       = 1'b0;
        rej       = 1'b0;
        snap_load = 1'b0;
        if (exec) begin
            case (op)
                4'd4: begin
                    if (pay != '0) gate_ok = 1'b1;
                    else           rej     = 1'b1;
                end
                4'd5: begin
                    if (int'(sel) < NCH) begin
                        rd_ok     = 1'b1;
                        rd_word   = chan_word;
                        snap_load = (sel == 4'd0);
                    end else if (sel == 4'd14) begin
                        rd_ok   = 1'b1;
                        rd_word = DATA_W'(ID_WORD);
                    end else if (sel == 4'd15) begin
                        rd_ok   = 1'b1;
                        rd_word = DATA_W'({err_cnt, 7'd0, busy_seen});
                    end else begin
                        rej = 1'b1;
                    end
                end
                4'd6:    clr = 1'b1;
                default: rej = 1'b1;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            spi_tx_data <= '0;
            gate_time   <= GATE_DEFAULT;
            gate_update <= 1'b0;
            cmd_done    <= 1'b0;
            cmd_err     <= 1'b0;
            err_cnt     <= 8'd0;
            busy_seen   <= 1'b0;
        end else begin
            gate_update <= gate_ok;
            cmd_done    <= exec;
            cmd_err     <= rej;
            if (rd_ok)   spi_tx_data <= rd_word;
            if (gate_ok) gate_time   <= pay;
            if (clr)                         err_cnt <= 8'd0;
            else if (rej && err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
            // A dropped strobe is newer information than a clear in the same cycle.
            if (drop)     busy_seen <= 1'b1;
            else if (clr) busy_seen <= 1'b0;
        end
    end

endmodule

// File: tb/tb_frecmd_regbank.sv
// Self-checking bench for frecmd_regbank: directed plan items plus randomized commands vs a reference model.
module tb_frecmd_regbank;

    localparam int NCH = 4;
    localparam logic [23:0] GDEF = 24'd1_000_000;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [31:0]       chv [NCH];
    logic [NCH*32-1:0] ch_data;
    logic [31:0]       spi_rx_data = '0;
    logic              spi_rx_valid = 1'b0;
    logic [31:0]       spi_tx_data;
    logic [23:0]       gate_time;
    logic              gate_update, cmd_done, cmd_err;

    int n_chk = 0;
    int n_err = 0;

    // reference model state
    logic [31:0] m_tx;
    logic [23:0] m_gate;
    int          m_errc;
    logic        m_busy;
    logic [31:0] m_shadow [NCH];

    always #5 clk = ~clk;

    always_comb begin
        for (int k = 0; k < NCH; k++) ch_data[k*32 +: 32] = chv[k];
    end

    frecmd_regbank #(.DATA_W(32), .NCH(NCH), .GATE_W(24)) dut (
        .clk(clk), .rst(rst), .ch_data(ch_data),
        .spi_rx_data(spi_rx_data), .spi_rx_valid(spi_rx_valid),
        .spi_tx_data(spi_tx_data), .gate_time(gate_time),
        .gate_update(gate_update), .cmd_done(cmd_done), .cmd_err(cmd_err)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_tx = '0; m_gate = GDEF; m_errc = 0; m_busy = 1'b0;
        for (int k = 0; k < NCH; k++) m_shadow[k] = '0;
    endtask

    task automatic model_cmd(input logic [31:0] w, output logic e, output logic u);
        int op, sel;
        logic [23:0] pay;
        op = int'(w[31:28]); sel = int'(w[27:24]); pay = w[23:0];
        e = 1'b0; u = 1'b0;
        if (op == 4) begin
            if (pay != 0) begin m_gate = pay; u = 1'b1; end
            else e = 1'b1;
        end else if (op == 5) begin
            if (sel < NCH) begin
`ifdef FRECMD_SNAPSHOT_EN
                if (sel == 0) begin
                    for (int k = 0; k < NCH; k++) m_shadow[k] = chv[k];
                    m_tx = chv[0];
                end else m_tx = m_shadow[sel];
`else
                m_tx = chv[sel];
`endif
            end else if (sel == 14) m_tx = 32'h0000_5AA5;
            else if (sel == 15)    m_tx = (m_errc * 256) + (m_busy ? 1 : 0);
            else e = 1'b1;
        end else if (op == 6) begin
            m_errc = 0; m_busy = 1'b0;
        end else e = 1'b1;
        if (e && m_errc < 255) m_errc++;
    endtask

    task automatic check_outputs(input string tag, input logic e, input logic u);
        chk({tag, ".done"}, 32'(cmd_done), 32'd1);
        chk({tag, ".err"},  32'(cmd_err), 32'(e));
        chk({tag, ".upd"},  32'(gate_update), 32'(u));
        chk({tag, ".tx"},   spi_tx_data, m_tx);
        chk({tag, ".gate"}, 32'(gate_time), 32'(m_gate));
    endtask

    task automatic do_cmd(input string tag, input logic [31:0] w);
        logic e, u;
        @(negedge clk); spi_rx_data = w; spi_rx_valid = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk); spi_rx_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        model_cmd(w, e, u);
        check_outputs(tag, e, u);
        @(posedge clk); #1;
        chk({tag, ".pulse"}, 32'({cmd_done, cmd_err, gate_update}), 32'd0);
    endtask

    initial begin
        logic e, u;
        logic [31:0] w;
        for (int k = 0; k < NCH; k++) chv[k] = 32'h1000_0000 + k;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("rst.tx", spi_tx_data, 32'd0);
        chk("rst.gate", 32'(gate_time), 32'(GDEF));
        chk("rst.pulses", 32'({cmd_done, cmd_err, gate_update}), 32'd0);
        @(negedge clk); rst = 1'b0;

        do_cmd("id", 32'h5E00_0000);
        chk("id.value", spi_tx_data, 32'h0000_5AA5);
        do_cmd("gw100", 32'h4000_0064);
        chk("gw100.value", 32'(gate_time), 32'd100);
        do_cmd("gw0", 32'h4000_0000);
        chk("gw0.gate", 32'(gate_time), 32'd100);
        chv[2] = 32'h1234_5678;
        do_cmd("rd0", 32'h5000_0000);
        do_cmd("rd2", 32'h5200_0000);
        chk("rd2.value", spi_tx_data, 32'h1234_5678);
        do_cmd("rd7", 32'h5700_0000);
        do_cmd("stat1", 32'h5F00_0000);
        chk("stat1.errcnt", spi_tx_data, 32'h0000_0200);

        // second strobe two clocks after the first must be dropped
        @(negedge clk); spi_rx_data = 32'h5E00_0000; spi_rx_valid = 1'b1;
        @(posedge clk);
        @(negedge clk); spi_rx_valid = 1'b0;
        @(posedge clk);
        @(negedge clk); spi_rx_data = 32'h4000_0077; spi_rx_valid = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        model_cmd(32'h5E00_0000, e, u);
        check_outputs("busy1", e, u);
        m_busy = 1'b1;
        @(negedge clk); spi_rx_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("busy.nodone", 32'(cmd_done), 32'd0);
        chk("busy.gate", 32'(gate_time), 32'd100);
        do_cmd("stat2", 32'h5F00_0000);
        chk("stat2.bit0", 32'(spi_tx_data[0]), 32'd1);
        do_cmd("clr", 32'h6000_0000);
        do_cmd("stat3", 32'h5F00_0000);
        chk("stat3.zero", spi_tx_data, 32'd0);

        for (int i = 0; i < 256; i++) do_cmd("op9", 32'h9000_0000 + 32'(i));
        do_cmd("stat4", 32'h5F00_0000);
        chk("stat4.sat", 32'(spi_tx_data[15:8]), 32'd255);

        // coherent snapshot check
        chv[1] = 32'h0000_000A;
        do_cmd("snap0", 32'h5000_0000);
        chv[1] = 32'h0000_000B;
        do_cmd("snap1", 32'h5100_0000);
`ifdef FRECMD_SNAPSHOT_EN
        chk("snap1.value", spi_tx_data, 32'h0000_000A);
`else
        chk("snap1.value", spi_tx_data, 32'h0000_000B);
`endif

        for (int i = 0; i < 80; i++) begin
            for (int k = 0; k < NCH; k++) chv[k] = $urandom;
            w = $urandom;
            case ($urandom_range(0, 4))
                0: w[31:28] = 4'd4;
                1: w[31:28] = 4'd5;
                2: begin w[31:28] = 4'd5; w[27:24] = 4'($urandom_range(0, NCH-1)); end
                3: begin w[31:28] = 4'd4; if ($urandom_range(0, 2) == 0) w[23:0] = '0; end
                default: ;
            endcase
            do_cmd("rand", w);
        end
        do_cmd("stat5", 32'h5F00_0000);

        // reset while a gate write sits in EXEC
        @(negedge clk); spi_rx_data = 32'h4000_00AA; spi_rx_valid = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        chk("rstx.gate", 32'(gate_time), 32'(GDEF));
        chk("rstx.pulses", 32'({cmd_done, cmd_err, gate_update}), 32'd0);
        @(negedge clk); spi_rx_valid = 1'b0;
        @(negedge clk); rst = 1'b0;
        model_reset();
        repeat (4) @(posedge clk);
        #1;
        chk("rstx.after_gate", 32'(gate_time), 32'(GDEF));
        chk("rstx.after_upd", 32'(gate_update), 32'd0);
        do_cmd("post", 32'h5F00_0000);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/frecmd_regbank.md
# frecmd_regbank

Parametrised SPI command decoder and register bank for the pulse-measurement core. It sits between the SPI slave (received word plus strobe) and the measurement channels. It decodes 32-bit-class command words into gate-time writes, channel readbacks, an ID/status readback and an error-counter clear, and it returns the readback word to the SPI transmit register. It generalises the earlier single-gate, three-channel decoder to NCH channels, configurable widths, error reporting and an optional coherent snapshot.

## Interface
Parameters:
- DATA_W, 32, command/readback word width; must be ≥16.
- NCH, 4, number of measurement channels; range 1..14.
- GATE_W, 24, gate-time payload width; must be ≤ DATA_W-8.
- GATE_DEFAULT, 24'd1_000_000, gate_time value after reset.
- ID_WORD, 16'h5AA5, value returned by the ID readback; zero-extended to DATA_W.

Ports:
- clk, input, 1, single system clock; all logic rises on posedge.
- rst, input, 1, reset; **asynchronous, active-high**.
- ch_data, input, NCH*DATA_W, channel results; channel k occupies bits [k*DATA_W +: DATA_W].
- spi_rx_data, input, DATA_W, last received SPI word.
- spi_rx_valid, input, 1, level strobe from the SPI slave; a rising edge marks a new word.
- spi_tx_data, output, DATA_W, readback word for the next SPI transfer.
- gate_time, output, GATE_W, current gate time in clk cycles.
- gate_update, output, 1, one-cycle pulse when gate_time changes.
- cmd_done, output, 1, one-cycle pulse when any command completes, including errored commands.
- cmd_err, output, 1, one-cycle pulse, coincident with cmd_done, when a command is rejected.

## Operation
- Command fields:
  - op = spi_rx_data[DATA_W-1 -: 4]
  - sel = spi_rx_data[DATA_W-5 -: 4]
  - pay = spi_rx_data[GATE_W-1:0]
- Edge detect: r1<=spi_rx_valid, r2<=r1, pos = r1 & ~r2. Both flops reset to 0.
- FSM states: IDLE, DECODE, EXEC.
  - IDLE→DECODE when pos is high; otherwise stay in IDLE.
  - DECODE→EXEC unconditionally; DECODE latches op, sel and pay.
  - EXEC→IDLE unconditionally.
- A pos that arrives while the FSM is not in IDLE is dropped silently.
- EXEC actions:
  - op=4, write gate:
    - pay≠0: gate_time<=pay and gate_update pulses.
    - pay=0: rejected (cmd_err); gate_time unchanged.
  - op=5, read:
    - sel<NCH: spi_tx_data<=channel sel.
    - sel=14: spi_tx_data<=ID_WORD.
    - sel=15: spi_tx_data<=status word = {zero-pad, err_cnt[7:0], 7'd0, busy_seen}.
    - Any other sel is rejected; spi_tx_data is unchanged.
  - op=6, clear: err_cnt<=0 and busy_seen<=0.
  - Any other op: rejected.
- err_cnt is 8 bits. It increments on every rejection and saturates at 255.
- busy_seen is a sticky flag, set when a pos is dropped.
- If a rejection and a dropped pos occur in the same cycle, both take effect.
- Reset values:
  - state=IDLE
  - spi_tx_data=0
  - gate_time=GATE_DEFAULT
  - gate_update=0, cmd_done=0, cmd_err=0
  - err_cnt=0, busy_seen=0
- Reset asserted mid-command aborts the command immediately. No partial update survives.

## Timing
- Edge 0: spi_rx_valid first sampled high. pos is high during cycle 0→1.
- Edge 1: state=DECODE and the fields are latched. spi_rx_data must be stable from edge 0 through edge 1.
- Edge 2: state=EXEC.
- Edge 3: outputs update and state=IDLE. cmd_done, cmd_err and gate_update are high for the single cycle that follows.
- Latency from strobe sampling to spi_tx_data/gate_time valid: 3 clk.
- Minimum command spacing: 3 clk between rising edges of spi_rx_valid. A tighter edge is dropped and sets busy_seen.
- spi_rx_valid held high re-triggers nothing; a new command requires a low then a high.

## Configuration
- FRECMD_SNAPSHOT_EN defined:
  - A read of sel=0 copies all NCH channels into shadow registers in EXEC and returns channel 0.
  - Reads of sel 1..NCH-1 return the shadow copies, so one measurement set reads back coherently.
  - Shadows reset to 0.
- FRECMD_SNAPSHOT_EN undefined:
  - No shadow registers exist.
  - Every channel read returns live ch_data sampled in EXEC.

## Test plan
- Reset, then read sel=14 (word 0x5E000000) → spi_tx_data=0x00005AA5 3 clk after strobe; cmd_done=1 for 1 cycle; cmd_err=0.
- Write gate 0x40000064 → gate_time=100, gate_update pulses once; then write 0x40000000 → cmd_err pulses, gate_time stays 100, err_cnt=1.
- NCH=4, ch2=0x12345678, read 0x52000000 → spi_tx_data=0x12345678; read 0x57000000 → cmd_err pulses, spi_tx_data unchanged.
- Two strobes 2 clk apart → only the first executes. Status read 0x5F000000 → bit0=1; after clear 0x60000000, the status read returns 0.
- 256 invalid ops (op=0x9) → err_cnt saturates at 255. Assert rst during EXEC of a gate write → gate_time=GATE_DEFAULT and no gate_update.
- With FRECMD_SNAPSHOT_EN: read ch0, change ch1 from 0xA to 0xB, read ch1 → 0xA. Without the macro → 0xB.
